// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial a - b - bin, LSB first, one full-subtractor cell
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_d;
  logic [W-1:0]   a_sh, b_sh, r_sh;
  logic           borrow;
  logic [CW-1:0]  cnt;
  logic           last, accept;
  logic           x, y, br, d, bnext;

  assign x      = a_sh[0];
  assign y      = b_sh[0];
  assign br     = borrow;
  assign d      = x ^ y ^ br;
  assign bnext  = (~x & y) | (~(x ^ y) & br);
  assign last   = (cnt == CW'(W - 1));
  // start is honoured in IDLE and in the DONE cycle, never mid-operation
  assign accept = start && (state != SHIFT);

  always_comb begin
    state_d = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_sgn, b_sgn;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sgn <= 1'b0;
      b_sgn <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sgn <= a[W-1];
      b_sgn <= b[W-1];
    end else if (state == SHIFT && last) begin
      // d is the result sign bit on the final cycle
      ovf <= (a_sgn != b_sgn) && (d != a_sgn);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= bin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      r_sh   <= {d, r_sh[W-1:1]};
      borrow <= bnext;
      cnt    <= cnt + 1'b1;
      // diff is a separate register so partial results never leak out
      if (last) begin
        diff <= {d, r_sh[W-1:1]};
        bout <= bnext;
      end
    end
  end

endmodule
